// File: rtl/fetch_pkg.sv
// Shared core definitions for the instruction-fetch stage and its BRAM wrapper.
package fetch_pkg;

  localparam int unsigned INSN_WIDTH      = 32;
  localparam int unsigned IMEM_ADDR_WIDTH = 15;

  localparam logic [INSN_WIDTH-1:0] NOP_INSN = 32'h0000_0000;

  typedef enum logic [1:0] {
    FETCH_IDLE = 2'd0,
    FETCH_REQ  = 2'd1,
    FETCH_WAIT = 2'd2
  } fetch_state_e;

  // Payload handed to decode once a fetch completes.
  typedef struct packed {
    logic [31:0]           pc;
    logic [INSN_WIDTH-1:0] insn;
    logic                  misaligned;
  } fetch_pkt_t;

endpackage

// File: rtl/fetch_if.sv
// Fetch-stage bus: controller/decode handshake plus the instruction BRAM port.
interface fetch_if #(
  parameter int unsigned ADDR_WIDTH = fetch_pkg::IMEM_ADDR_WIDTH
);

  logic                  enable;
  logic [31:0]           pc_in;
  logic                  done;
  logic [31:0]           pc_out;
  logic [31:0]           command;
  logic                  misaligned;
  logic                  imem_en;
  logic [ADDR_WIDTH-1:0] imem_addr;
  logic [31:0]           imem_dout;

  modport master (
    input  enable, pc_in, imem_dout,
    output done, pc_out, command, misaligned, imem_en, imem_addr
  );

  modport slave (
    output enable, pc_in, imem_dout,
    input  done, pc_out, command, misaligned, imem_en, imem_addr
  );

endinterface

// File: rtl/fetch.sv
// Instruction-fetch stage: one BRAM read per enable, result held for decode
// with a single-cycle done pulse.
module fetch
  import fetch_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = IMEM_ADDR_WIDTH,
  parameter int unsigned MEM_LATENCY = 2
) (
  input  logic     clk,
  input  logic     rstn,
  fetch_if.master  bus
);

  localparam int unsigned CNT_W = 3;

  fetch_state_e          state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  fetch_pkt_t            pkt_q, pkt_d;
  logic                  done_q, done_d;
  logic                  en_q, en_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;

  // Next-state and next-output logic; done and imem_en default low so they pulse.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pkt_d   = pkt_q;
    done_d  = 1'b0;
    en_d    = 1'b0;
    addr_d  = addr_q;
    unique case (state_q)
      FETCH_IDLE: begin
        if (bus.enable) begin
          pkt_d.pc         = bus.pc_in;
          pkt_d.misaligned = |bus.pc_in[1:0];
          addr_d           = bus.pc_in[ADDR_WIDTH+1:2];
          en_d             = 1'b1;
          state_d          = FETCH_REQ;
        end
      end
      FETCH_REQ: begin
        cnt_d   = CNT_W'(1);
        state_d = FETCH_WAIT;
      end
      FETCH_WAIT: begin
        // cnt_q counts cycles since the request; data is valid when it hits the latency.
        if (cnt_q == CNT_W'(MEM_LATENCY)) begin
          pkt_d.insn = bus.imem_dout;
          done_d     = 1'b1;
          cnt_d      = '0;
          state_d    = FETCH_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = FETCH_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= FETCH_IDLE;
      cnt_q   <= '0;
      pkt_q   <= '{pc: 32'h0, insn: NOP_INSN, misaligned: 1'b0};
      done_q  <= 1'b0;
      en_q    <= 1'b0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pkt_q   <= pkt_d;
      done_q  <= done_d;
      en_q    <= en_d;
      addr_q  <= addr_d;
    end
  end

  assign bus.done       = done_q;
  assign bus.pc_out     = pkt_q.pc;
  assign bus.command    = pkt_q.insn;
  assign bus.misaligned = pkt_q.misaligned;
  assign bus.imem_en    = en_q;
  assign bus.imem_addr  = addr_q;

endmodule

// File: tb/tb_fetch.sv
// Self-checking bench for fetch: directed table, multi-cycle corner sequences,
// and random traffic against a countdown-based reference model.
module tb_fetch;

  localparam int unsigned AW = 15;
  localparam int unsigned L  = 2;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  fetch_if #(.ADDR_WIDTH(AW)) bus ();

  fetch #(.ADDR_WIDTH(AW), .MEM_LATENCY(L)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  // BRAM model: read data emerges L cycles after the enable cycle, junk otherwise.
  logic [31:0] mem [2**AW];
  logic [31:0] dpipe [L];
  always @(posedge clk) begin
    dpipe[0] <= bus.imem_en ? mem[bus.imem_addr] : $urandom;
    for (int i = 1; i < L; i++) dpipe[i] <= dpipe[i-1];
  end
  assign bus.imem_dout = dpipe[L-1];

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;

  // Reference model: a fetch is a countdown of L+1 edges from accept to capture.
  int          m_remain;
  logic [31:0] m_pc, m_cmd;
  logic        m_mis, m_done, m_en;
  logic [AW-1:0] m_addr;

  task automatic model_edge();
    m_done = 1'b0;
    m_en   = 1'b0;
    if (!rstn) begin
      m_remain = 0; m_pc = 0; m_cmd = 0; m_mis = 0; m_addr = '0;
    end else if (m_remain > 0) begin
      m_remain--;
      if (m_remain == 0) begin
        m_cmd  = mem[m_addr];
        m_done = 1'b1;
      end
    end else if (bus.enable) begin
      m_pc     = bus.pc_in;
      m_mis    = (bus.pc_in % 4) != 0;
      m_addr   = AW'((bus.pc_in >> 2) & ((32'd1 << AW) - 1));
      m_en     = 1'b1;
      m_remain = L + 1;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic compare_model();
    chk("done",       32'(bus.done),       32'(m_done));
    chk("imem_en",    32'(bus.imem_en),    32'(m_en));
    chk("imem_addr",  32'(bus.imem_addr),  32'(m_addr));
    chk("pc_out",     bus.pc_out,          m_pc);
    chk("command",    bus.command,         m_cmd);
    chk("misaligned", 32'(bus.misaligned), 32'(m_mis));
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    cyc++;
    compare_model();
  endtask

  typedef struct {
    logic [31:0]   pc;
    logic [31:0]   insn;
    logic [AW-1:0] exp_addr;
    logic          exp_mis;
  } vec_t;

  vec_t vecs [5];

  initial begin
    int k, dones, ens, last_done;
    for (int i = 0; i < 2**AW; i++) mem[i] = $urandom;
    for (int i = 0; i < int'(L); i++) dpipe[i] = $urandom;
    bus.enable = 1'b0;
    bus.pc_in  = 32'h0;

    vecs[0] = '{32'h0000_0010, 32'h2001_0005, 15'd4,      1'b0};
    vecs[1] = '{32'h0002_0004, 32'h1234_5678, 15'd1,      1'b0};
    vecs[2] = '{32'h0000_0006, 32'hDEAD_BEEF, 15'd1,      1'b1};
    vecs[3] = '{32'hFFFF_FFFC, 32'hCAFE_F00D, 15'h7FFF,   1'b0};
    vecs[4] = '{32'h0001_FFFF, 32'h0BAD_C0DE, 15'h7FFF,   1'b1};

    // Reset, then idle.
    #1;
    repeat (3) step();
    chk("rst_done",    32'(bus.done),    32'h0);
    chk("rst_imem_en", 32'(bus.imem_en), 32'h0);
    chk("rst_pc_out",  bus.pc_out,       32'h0);
    chk("rst_command", bus.command,      32'h0);
    rstn = 1'b1;
    repeat (10) step();
    chk("idle_done",   32'(bus.done),    32'h0);
    chk("idle_pc_out", bus.pc_out,       32'h0);

    // Directed table of single fetches.
    foreach (vecs[i]) begin
      mem[vecs[i].exp_addr] = vecs[i].insn;
      bus.enable = 1'b1;
      bus.pc_in  = vecs[i].pc;
      step();
      bus.enable = 1'b0;
      chk("tbl_imem_en",   32'(bus.imem_en),   32'h1);
      chk("tbl_imem_addr", 32'(bus.imem_addr), 32'(vecs[i].exp_addr));
      chk("tbl_pc_out",    bus.pc_out,         vecs[i].pc);
      k = 0;
      while (!bus.done && k < 10) begin step(); k++; end
      chk("tbl_latency",    32'(k),              32'(L + 1));
      chk("tbl_command",    bus.command,         vecs[i].insn);
      chk("tbl_misaligned", 32'(bus.misaligned), 32'(vecs[i].exp_mis));
      step();
      chk("tbl_done_pulse", 32'(bus.done), 32'h0);
      chk("tbl_cmd_hold",   bus.command,   vecs[i].insn);
    end

    // Back-to-back with enable held: a fetch every L+2 cycles.
    bus.enable = 1'b1;
    bus.pc_in  = 32'h0002_0004;
    dones = 0; last_done = -1;
    for (int s = 0; s < 12; s++) begin
      step();
      if (s == 0) chk("b2b_addr", 32'(bus.imem_addr), 32'h1);
      if (bus.done) begin
        if (last_done >= 0) chk("b2b_spacing", 32'(s - last_done), 32'(L + 2));
        last_done = s;
        dones++;
      end
    end
    bus.enable = 1'b0;
    chk("b2b_dones", 32'(dones), 32'd3);
    k = 0;
    while (!bus.done && k < 10) begin step(); k++; end
    step();

    // Enable while busy is dropped.
    dones = 0; ens = 0;
    for (int s = 0; s < 10; s++) begin
      bus.enable = (s == 0) || (s == 2);
      bus.pc_in  = (s == 0) ? 32'h8 : 32'h40;
      step();
      dones += int'(bus.done);
      ens   += int'(bus.imem_en);
      if (bus.done) chk("busy_done_cycle", 32'(s), 32'(L + 1));
    end
    bus.enable = 1'b0;
    chk("busy_dones",  32'(dones),    32'd1);
    chk("busy_en",     32'(ens),      32'd1);
    chk("busy_pc_out", bus.pc_out,    32'h8);

    // Reset mid-fetch: outputs clear at once, fetch never completes.
    bus.enable = 1'b1;
    bus.pc_in  = 32'h0000_0104;
    step();
    bus.enable = 1'b0;
    step();
    #2 rstn = 1'b0;
    #1;
    chk("mrst_done",    32'(bus.done),       32'h0);
    chk("mrst_imem_en", 32'(bus.imem_en),    32'h0);
    chk("mrst_addr",    32'(bus.imem_addr),  32'h0);
    chk("mrst_pc_out",  bus.pc_out,          32'h0);
    chk("mrst_command", bus.command,         32'h0);
    chk("mrst_mis",     32'(bus.misaligned), 32'h0);
    step();
    rstn = 1'b1;
    dones = 0;
    for (int s = 0; s < 8; s++) begin step(); dones += int'(bus.done); end
    chk("mrst_no_done", 32'(dones), 32'd0);

    // Random traffic against the reference model.
    for (int s = 0; s < 500; s++) begin
      bus.enable = ($urandom_range(0, 2) != 0);
      bus.pc_in  = ($urandom_range(0, 1) != 0) ? $urandom : 32'($urandom_range(0, 255));
      step();
    end
    bus.enable = 1'b0;
    repeat (8) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
